// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared constants for the 7-segment scan controller:
//   - segment bit positions within the 8-bit segment bus (a..g, dp)
//   - hex digit patterns 0..F (dp bit clear, active-high segments)
//   - scan FSM state encoding
package seven_segment_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] HEX_0 = 8'hFC;
  localparam logic [7:0] HEX_1 = 8'h60;
  localparam logic [7:0] HEX_2 = 8'hDA;
  localparam logic [7:0] HEX_3 = 8'hF2;
  localparam logic [7:0] HEX_4 = 8'h66;
  localparam logic [7:0] HEX_5 = 8'hB6;
  localparam logic [7:0] HEX_6 = 8'hBE;
  localparam logic [7:0] HEX_7 = 8'hE0;
  localparam logic [7:0] HEX_8 = 8'hFE;
  localparam logic [7:0] HEX_9 = 8'hF6;
  localparam logic [7:0] HEX_A = 8'hEE;
  localparam logic [7:0] HEX_B = 8'h3E;
  localparam logic [7:0] HEX_C = 8'h9C;
  localparam logic [7:0] HEX_D = 8'h7A;
  localparam logic [7:0] HEX_E = 8'h9E;
  localparam logic [7:0] HEX_F = 8'h8E;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/seven_segment_hex_decode.sv
// seven_segment_hex_decode
//   Combinational hex nibble to segment decoder, full 0..F coverage.
//   Ports:
//     nibble  in  4  hex digit
//     seg7    out 7  segments a..g (seg7[6] = a, seg7[0] = g), active-high
module seven_segment_hex_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  logic [7:0] pattern;

  always_comb begin
    pattern = HEX_0;
    case (nibble)
      4'h0: pattern = HEX_0;
      4'h1: pattern = HEX_1;
      4'h2: pattern = HEX_2;
      4'h3: pattern = HEX_3;
      4'h4: pattern = HEX_4;
      4'h5: pattern = HEX_5;
      4'h6: pattern = HEX_6;
      4'h7: pattern = HEX_7;
      4'h8: pattern = HEX_8;
      4'h9: pattern = HEX_9;
      4'hA: pattern = HEX_A;
      4'hB: pattern = HEX_B;
      4'hC: pattern = HEX_C;
      4'hD: pattern = HEX_D;
      4'hE: pattern = HEX_E;
      4'hF: pattern = HEX_F;
      default: pattern = HEX_0;
    endcase
  end

  assign seg7 = pattern[SEG_A:SEG_G];

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit 7-segment display.
//   A new value is taken over valid/ready into a shadow register and only
//   copied to the display at the start of a frame, so digits never tear.
//   Each digit slot starts with a blanking gap to suppress ghosting.
//
//   State table:
//     BLANK | all digits off, seg_out = 0, first BLANK_CYCLES of the slot
//     SHOW  | digit_en[idx] on, seg_out = decoded digit idx, rest of the slot
//
//   Ports:
//     clk          in   1           system clock
//     rst          in   1           synchronous active-high reset
//     value_in     in   4*DIGITS    packed nibbles, nibble i -> digit i
//     dp_in        in   DIGITS      decimal point per digit
//     value_valid  in   1           producer presents value_in/dp_in
//     value_ready  out  1           shadow register free
//     blank_lz     in   1           leading-zero blanking enable (live)
//     seg_out      out  8           {a,b,c,d,e,f,g,dp}, active-high
//     digit_en     out  DIGITS      one-hot digit enable
//     frame_start  out  1           pulse when the digit-0 slot begins
module seven_segment_scan_ctrl
  import seven_segment_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int PRESCALE         = 12000,
  parameter int BLANK_CYCLES     = 64,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_start
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] EN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [DIGITS-1:0] EN_OFF = (DIGIT_ACTIVE_LOW != 0) ?
                                         {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [0:0]            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  pending;
  logic [4*DIGITS-1:0]   shadow_val, disp_val;
  logic [DIGITS-1:0]     shadow_dp, disp_dp;

  logic                  last_cnt, last_blank, last_idx, commit_edge;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg7;
  logic                  upper_zero, lz_hit;
  logic [7:0]            seg_show;

  assign value_ready = !pending;

  assign last_cnt   = (cnt == CW'(PRESCALE - 1));
  assign last_blank = (cnt == CW'(BLANK_CYCLES - 1));
  assign last_idx   = (idx == IW'(DIGITS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (last_blank) state_nxt = ST_SHOW;
      ST_SHOW:  if (last_cnt)   state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  assign cnt_nxt = last_cnt ? '0 : cnt + 1'b1;
  assign idx_nxt = (state == ST_SHOW && last_cnt) ?
                   (last_idx ? '0 : idx + 1'b1) : idx;

  // The edge that enters the BLANK gap of digit 0 is the frame boundary.
  assign commit_edge = (state == ST_SHOW) && last_cnt && last_idx;

  assign cur_nibble = disp_val[4*int'(idx) +: 4];

  seven_segment_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg7   (cur_seg7)
  );

  // Walk down from the top digit; a digit is a leading zero if it and
  // everything above it are zero. Digit 0 is never visited.
  always_comb begin
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      if (IW'(i) == idx) lz_hit = upper_zero;
    end
  end

  assign seg_show = {(blank_lz && lz_hit) ? 7'b0 : cur_seg7, disp_dp[idx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      frame_start <= 1'b0;
      seg_out     <= 8'h00;
      digit_en    <= EN_OFF;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= commit_edge;

      // Commit needs pending set and accept needs it clear, so they
      // never coincide; a valid in the commit cycle waits one more cycle.
      if (commit_edge && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pending  <= 1'b0;
      end else if (value_valid && !pending) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end

      // Entering or staying in SHOW never changes idx or the display
      // registers on this edge, so the current values are the ones shown.
      if (state_nxt == ST_SHOW) begin
        seg_out  <= seg_show;
        digit_en <= EN_OFF ^ (EN_ONE << idx);
      end else begin
        seg_out  <= 8'h00;
        digit_en <= EN_OFF;
      end
    end
  end

endmodule
